// File: rtl/datapath_sequencer_pkg.sv
// Shared encodings for the datapath sequencer: FSM states, ISA opcode/op fields,
// ALU operation and writeback-source codes, and the decoded instruction class.
package seq_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WR_IMM,
        GET_A,
        GET_B,
        EXEC,
        WR_REG
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOTB   = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;

    typedef enum logic [2:0] {
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD_AND,
        CLS_CMP,
        CLS_MVN,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/datapath_sequencer_instr_decoder.sv
// Combinational instruction decoder: splits the latched instruction into register
// fields, sign-extends imm8 and classifies the instruction for the sequencer.
module instr_decoder
    import seq_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_SEL_W = 3
) (
    input  logic [DATA_W-1:0]    ir,
    output logic [1:0]           op,
    output logic [REG_SEL_W-1:0] rn,
    output logic [REG_SEL_W-1:0] rd,
    output logic [REG_SEL_W-1:0] rm,
    output logic [1:0]           sh,
    output logic [DATA_W-1:0]    sximm8,
    output instr_class_t         cls,
    output logic                 legal
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    always_comb begin
        cls = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM) begin
                cls = CLS_MOV_IMM;
            end else if (op == OP_MOV_REG) begin
                cls = CLS_MOV_REG;
            end
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD, OP_AND: cls = CLS_ADD_AND;
                OP_CMP:         cls = CLS_CMP;
                OP_MVN:         cls = CLS_MVN;
                default:        cls = CLS_ILLEGAL;
            endcase
        end
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle Moore controller for the 16-bit ALU datapath: latches an instruction
// in WAIT, then steps through decode, operand fetch, execute and writeback states.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s,
    input  logic                 load,
    input  logic [DATA_W-1:0]    in,
    output logic                 w,
    output logic [REG_SEL_W-1:0] readnum,
    output logic [REG_SEL_W-1:0] writenum,
    output logic                 write,
    output logic                 loada,
    output logic                 loadb,
    output logic                 loadc,
    output logic                 loads,
    output logic                 asel,
    output logic                 bsel,
    output logic [1:0]           vsel,
    output logic [1:0]           shift,
    output logic [1:0]           ALUop,
    output logic [DATA_W-1:0]    sximm8,
    output logic                 illegal
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   ir_q, ir_d;

    logic [1:0]           op;
    logic [REG_SEL_W-1:0] rn, rd, rm;
    logic [1:0]           sh;
    instr_class_t         cls;
    logic                 legal;

    instr_decoder #(
        .DATA_W    (DATA_W),
        .REG_SEL_W (REG_SEL_W)
    ) u_dec (
        .ir     (ir_q),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm8 (sximm8),
        .cls    (cls),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        shift    = '0;
        ALUop    = ALU_ADD;
        illegal  = 1'b0;

        case (state_q)
            WAIT: begin
                w = 1'b1;
                // A load and a start on the same edge decode the newly loaded word.
                if (load) ir_d = in;
                if (s)    state_d = DECODE;
            end
            DECODE: begin
                case (cls)
                    CLS_MOV_IMM:          state_d = WR_IMM;
                    CLS_MOV_REG, CLS_MVN: state_d = GET_B;
                    CLS_ADD_AND, CLS_CMP: state_d = GET_A;
                    default: begin
                        illegal = !legal;
                        state_d = WAIT;
                    end
                endcase
            end
            WR_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
                state_d  = WAIT;
            end
            GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = GET_B;
            end
            GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                shift = sh;
                if (cls == CLS_MOV_REG) begin
                    ALUop = ALU_ADD;
                    asel  = 1'b1;
                end else begin
                    ALUop = op;
                end
                if (cls == CLS_CMP) begin
                    loads   = 1'b1;
                    state_d = WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = WR_REG;
                end
            end
            WR_REG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                state_d  = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer: per-cycle output snapshots are compared
// against hand-written expected traces for each instruction class and corner case.
module tb_datapath_sequencer;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic        load;
    logic [15:0] in_w;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [20:0] trace [8];
    int          n_cap;
    logic [15:0] sx_cap;

    datapath_sequencer #(
        .DATA_W    (16),
        .REG_SEL_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .load     (load),
        .in       (in_w),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (aluop),
        .sximm8   (sximm8),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot layout: {w, illegal, write, loada, loadb, loadc, loads, asel, bsel,
    //                   vsel[1:0], shift[1:0], ALUop[1:0], readnum[2:0], writenum[2:0]}
    function automatic logic [20:0] snap();
        return {w, illegal, write, loada, loadb, loadc, loads, asel, bsel,
                vsel, shift, aluop, readnum, writenum};
    endfunction

    function automatic logic [20:0] pk(
        input logic ew, input logic eill, input logic ewr, input logic ela,
        input logic elb, input logic elc, input logic els, input logic eas,
        input logic [1:0] evs, input logic [1:0] esh, input logic [1:0] ealu,
        input logic [2:0] ern, input logic [2:0] ewn);
        return {ew, eill, ewr, ela, elb, elc, els, eas, 1'b0, evs, esh, ealu, ern, ewn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load and start one instruction, then record every cycle up to and including
    // the first cycle with w=1 (bounded at 8 cycles).
    task automatic capture(input logic [15:0] word);
        in_w = word;
        load = 1'b1;
        s    = 1'b1;
        step();
        load = 1'b0;
        s    = 1'b0;
        n_cap  = 0;
        sx_cap = sximm8;
        for (int i = 0; i < 8; i++) begin
            trace[i] = snap();
            n_cap++;
            if (w) break;
            step();
        end
    endtask

    task automatic test_reset();
        logic [20:0] idle;
        idle  = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        rst_n = 1'b0;
        s     = 1'b0;
        load  = 1'b0;
        in_w  = 16'h0000;
        step();
        step();
        checks++;
        if (snap() !== idle) begin
            errors++;
            $display("FAIL reset_during got %h want %h", snap(), idle);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (snap() !== idle) begin
                errors++;
                $display("FAIL reset_idle[%0d] got %h want %h", i, snap(), idle);
            end
        end
        checks++;
        if (sximm8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ir got %h want 0000", sximm8);
        end
    endtask

    task automatic test_load_only();
        in_w = 16'hD1FE;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (sximm8 !== 16'hFFFE) begin
            errors++;
            $display("FAIL load_only_ir got %h want FFFE", sximm8);
        end
        step();
        checks++;
        if (w !== 1'b1) begin
            errors++;
            $display("FAIL load_only_wait got w=%b want 1", w);
        end
    endtask

    task automatic test_mov_imm(input logic [15:0] word, input logic [2:0] rn,
                                input logic [15:0] imm);
        logic [20:0] e [3];
        e[0] = pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e[1] = pk(0,0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'd0,rn);
        e[2] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        capture(word);
        checks++;
        if (sx_cap !== imm) begin
            errors++;
            $display("FAIL mov_imm_sximm8 %h got %h want %h", word, sx_cap, imm);
        end
        checks++;
        if (n_cap !== 3) begin
            errors++;
            $display("FAIL mov_imm_len %h got %0d want 3", word, n_cap);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (trace[i] !== e[i]) begin
                errors++;
                $display("FAIL mov_imm %h cyc%0d got %h want %h", word, i, trace[i], e[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [20:0] e [6];
        e[0] = pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e[1] = pk(0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0);
        e[2] = pk(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e[3] = pk(0,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,3'd0,3'd0);
        e[4] = pk(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd2);
        e[5] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        capture(16'hA148);
        checks++;
        if (n_cap !== 6) begin
            errors++;
            $display("FAIL add_len got %0d want 6", n_cap);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (trace[i] !== e[i]) begin
                errors++;
                $display("FAIL add cyc%0d got %h want %h", i, trace[i], e[i]);
            end
        end
    endtask

    task automatic test_cmp();
        logic [20:0] e [5];
        e[0] = pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e[1] = pk(0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e[2] = pk(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0);
        e[3] = pk(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b01,3'd0,3'd0);
        e[4] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        capture(16'hA801);
        checks++;
        if (n_cap !== 5) begin
            errors++;
            $display("FAIL cmp_len got %0d want 5", n_cap);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (trace[i] !== e[i]) begin
                errors++;
                $display("FAIL cmp cyc%0d got %h want %h", i, trace[i], e[i]);
            end
        end
    endtask

    task automatic test_single_operand();
        logic [20:0] e_mvn [5];
        logic [20:0] e_mov [5];
        e_mvn[0] = pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e_mvn[1] = pk(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e_mvn[2] = pk(0,0,0,0,0,1,0,0,2'b00,2'b00,2'b11,3'd0,3'd0);
        e_mvn[3] = pk(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd3);
        e_mvn[4] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        // MOV R4, R2 LSL#2-code: Rd=4, sh=10, Rm=2
        e_mov[0] = pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e_mov[1] = pk(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd2,3'd0);
        e_mov[2] = pk(0,0,0,0,0,1,0,1,2'b00,2'b10,2'b00,3'd0,3'd0);
        e_mov[3] = pk(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd4);
        e_mov[4] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        capture(16'hB860);
        checks++;
        if (n_cap !== 5) begin
            errors++;
            $display("FAIL mvn_len got %0d want 5", n_cap);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (trace[i] !== e_mvn[i]) begin
                errors++;
                $display("FAIL mvn cyc%0d got %h want %h", i, trace[i], e_mvn[i]);
            end
        end
        capture(16'hC092);
        checks++;
        if (n_cap !== 5) begin
            errors++;
            $display("FAIL mov_reg_len got %0d want 5", n_cap);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (trace[i] !== e_mov[i]) begin
                errors++;
                $display("FAIL mov_reg cyc%0d got %h want %h", i, trace[i], e_mov[i]);
            end
        end
    endtask

    task automatic test_illegal(input logic [15:0] word);
        logic [20:0] e [2];
        e[0] = pk(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        e[1] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        capture(word);
        checks++;
        if (n_cap !== 2) begin
            errors++;
            $display("FAIL illegal_len %h got %0d want 2", word, n_cap);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (trace[i] !== e[i]) begin
                errors++;
                $display("FAIL illegal %h cyc%0d got %h want %h", word, i, trace[i], e[i]);
            end
        end
    endtask

    // s and load held high throughout: the IR must not change mid-instruction and
    // w must be high for exactly one cycle between the two instructions.
    task automatic test_back_to_back();
        logic [20:0] exp_seq [6];
        logic [15:0] exp_sx  [6];
        exp_seq[0] = pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        exp_seq[1] = pk(0,0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'd0,3'd0);
        exp_seq[2] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        exp_seq[3] = pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        exp_seq[4] = pk(0,0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'd0,3'd1);
        exp_seq[5] = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        exp_sx[0] = 16'h0007;
        exp_sx[1] = 16'h0007;
        exp_sx[2] = 16'h0007;
        exp_sx[3] = 16'hFFFE;
        exp_sx[4] = 16'hFFFE;
        exp_sx[5] = 16'hFFFE;
        in_w = 16'hD007;
        load = 1'b1;
        s    = 1'b1;
        step();
        in_w = 16'hD1FE;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                s    = 1'b0;
                load = 1'b0;
            end
            checks++;
            if (snap() !== exp_seq[i]) begin
                errors++;
                $display("FAIL b2b cyc%0d got %h want %h", i, snap(), exp_seq[i]);
            end
            checks++;
            if (sximm8 !== exp_sx[i]) begin
                errors++;
                $display("FAIL b2b_ir cyc%0d got %h want %h", i, sximm8, exp_sx[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_reset_abort();
        logic [20:0] idle;
        idle = pk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
        in_w = 16'hA148;
        load = 1'b1;
        s    = 1'b1;
        step();
        load = 1'b0;
        s    = 1'b0;
        step();
        step();
        checks++;
        if (loadb !== 1'b1 || readnum !== 3'd0) begin
            errors++;
            $display("FAIL abort_getb got loadb=%b readnum=%0d want 1,0", loadb, readnum);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (sximm8 !== 16'h0000) begin
            errors++;
            $display("FAIL abort_ir got %h want 0000", sximm8);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (snap() !== idle) begin
                errors++;
                $display("FAIL abort_idle[%0d] got %h want %h", i, snap(), idle);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load_only();
        test_mov_imm(16'hD007, 3'd0, 16'h0007);
        test_mov_imm(16'hD1FE, 3'd1, 16'hFFFE);
        test_add();
        test_cmp();
        test_single_operand();
        test_illegal(16'hE000);
        test_illegal(16'hC800);
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
